generador_sync_vga: RTL and testbench

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz Nexys board clock. It sits directly upstream of the VGA colour/character rendering stage. It supplies that stage with hsync/vsync, the current pixel coordinates, a visible-area flag and per-pixel/per-frame strobes. The rendering stage uses these to address its font ROM and to drive color_salida.

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/generador_sync_vga_if.sv | 24 ++
 rtl/divisor_tick_pixel.sv | 53 +++++
 rtl/generador_sync_vga.sv | 120 ++++++++++++
 tb/tb_generador_sync_vga.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Standard 640x480 @ 60 Hz VGA timing constants shared by the sync generator
// and the rendering stage that consumes its coordinates.
package vga_timing_pkg;

    localparam int VGA_DIV_PIXEL = 4;
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    localparam int CNT_W = $clog2((VGA_H_TOTAL > VGA_V_TOTAL) ? VGA_H_TOTAL : VGA_V_TOTAL);

    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic             video_on;
        logic [CNT_W-1:0] pixel_x;
        logic [CNT_W-1:0] pixel_y;
        logic             tick_pixel;
        logic             inicio_cuadro;
    } vga_sync_t;

    function automatic logic en_rango(input logic [CNT_W-1:0] valor, input int lo, input int hi);
        return (int'(valor) >= lo) && (int'(valor) <= hi);
    endfunction

endpackage

// File: rtl/generador_sync_vga_if.sv
// Timing bundle between the sync generator (master) and the renderer (slave);
// the renderer owns the count enable.
interface generador_sync_vga_if;

    logic                              habilitar;
    logic                              hsync;
    logic                              vsync;
    logic                              video_on;
    logic [vga_timing_pkg::CNT_W-1:0]  pixel_x;
    logic [vga_timing_pkg::CNT_W-1:0]  pixel_y;
    logic                              tick_pixel;
    logic                              inicio_cuadro;

    modport master (
        input  habilitar,
        output hsync, vsync, video_on, pixel_x, pixel_y, tick_pixel, inicio_cuadro
    );

    modport slave (
        output habilitar,
        input  hsync, vsync, video_on, pixel_x, pixel_y, tick_pixel, inicio_cuadro
    );

endinterface

// File: rtl/divisor_tick_pixel.sv
// Pixel clock divider: holds div_cnt and tells the top when the horizontal
// counter advances and whether the next state lands on a pixel boundary.
module divisor_tick_pixel #(
    parameter int DIV_PIXEL = 4
) (
    input  logic reloj_nexys,
    input  logic reset_total_n,
    input  logic habilitar,
    output logic avanza_h,
    output logic tick_sig
);

    localparam int DIV_W = (DIV_PIXEL > 1) ? $clog2(DIV_PIXEL) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV_PIXEL - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_cnt_s;
    // The first enabled edge after reset only publishes position (0,0); counting starts after it.
    logic             arrancado_r;

    // Next divider value and horizontal advance request.
    always_comb begin
        div_cnt_s = div_cnt_r;
        avanza_h  = 1'b0;
        if (habilitar && arrancado_r) begin
            if (div_cnt_r == DIV_MAX) begin
                div_cnt_s = '0;
                avanza_h  = 1'b1;
            end else begin
                div_cnt_s = div_cnt_r + DIV_W'(1);
            end
        end else begin
            div_cnt_s = div_cnt_r;
            avanza_h  = 1'b0;
        end
        tick_sig = (div_cnt_s == '0);
    end

    // Divider state register; frozen while habilitar is low.
    always_ff @(posedge reloj_nexys or negedge reset_total_n) begin
        if (!reset_total_n) begin
            div_cnt_r   <= '0;
            arrancado_r <= 1'b0;
        end else if (habilitar) begin
            div_cnt_r   <= div_cnt_s;
            arrancado_r <= 1'b1;
        end else begin
            div_cnt_r   <= div_cnt_r;
            arrancado_r <= arrancado_r;
        end
    end

endmodule

// File: rtl/generador_sync_vga.sv
// 640x480 VGA sync generator: h/v counters plus registered decode of the
// next-state counters, so every output is aligned with the counters it shows.
module generador_sync_vga
    import vga_timing_pkg::*;
#(
    parameter int   DIV_PIXEL   = VGA_DIV_PIXEL,
    parameter int   H_VISIBLE   = VGA_H_VISIBLE,
    parameter int   H_FP        = VGA_H_FP,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BP        = VGA_H_BP,
    parameter int   V_VISIBLE   = VGA_V_VISIBLE,
    parameter int   V_FP        = VGA_V_FP,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BP        = VGA_V_BP,
    parameter logic SYNC_ACTIVO = 1'b0
) (
    input  logic                 reloj_nexys,
    input  logic                 reset_total_n,
    generador_sync_vga_if.master bus
);

    localparam int H_TOTAL    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_INI = H_VISIBLE + H_FP;
    localparam int H_SYNC_FIN = H_SYNC_INI + H_SYNC - 1;
    localparam int V_SYNC_INI = V_VISIBLE + V_FP;
    localparam int V_SYNC_FIN = V_SYNC_INI + V_SYNC - 1;

    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_TOTAL - 1);

    localparam vga_sync_t SALIDA_RESET = '{
        hsync:         ~SYNC_ACTIVO,
        vsync:         ~SYNC_ACTIVO,
        video_on:      1'b0,
        pixel_x:       '0,
        pixel_y:       '0,
        tick_pixel:    1'b0,
        inicio_cuadro: 1'b0
    };

    logic             avanza_h_s;
    logic             tick_sig_s;
    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic [CNT_W-1:0] h_cnt_s;
    logic [CNT_W-1:0] v_cnt_s;
    vga_sync_t        salida_s;
    vga_sync_t        salida_r;

    divisor_tick_pixel #(
        .DIV_PIXEL (DIV_PIXEL)
    ) u_divisor (
        .reloj_nexys   (reloj_nexys),
        .reset_total_n (reset_total_n),
        .habilitar     (bus.habilitar),
        .avanza_h      (avanza_h_s),
        .tick_sig      (tick_sig_s)
    );

    // Next-state h/v counters; each compares against its wrap value before incrementing.
    always_comb begin
        h_cnt_s = h_cnt_r;
        v_cnt_s = v_cnt_r;
        if (avanza_h_s) begin
            if (h_cnt_r == H_MAX) begin
                h_cnt_s = '0;
                if (v_cnt_r == V_MAX) begin
                    v_cnt_s = '0;
                end else begin
                    v_cnt_s = v_cnt_r + CNT_W'(1);
                end
            end else begin
                h_cnt_s = h_cnt_r + CNT_W'(1);
                v_cnt_s = v_cnt_r;
            end
        end else begin
            h_cnt_s = h_cnt_r;
            v_cnt_s = v_cnt_r;
        end
    end

    // Output decode taken from the next-state counters.
    always_comb begin
        salida_s               = SALIDA_RESET;
        salida_s.hsync         = en_rango(h_cnt_s, H_SYNC_INI, H_SYNC_FIN) ? SYNC_ACTIVO : ~SYNC_ACTIVO;
        salida_s.vsync         = en_rango(v_cnt_s, V_SYNC_INI, V_SYNC_FIN) ? SYNC_ACTIVO : ~SYNC_ACTIVO;
        salida_s.video_on      = (int'(h_cnt_s) < H_VISIBLE) && (int'(v_cnt_s) < V_VISIBLE);
        salida_s.pixel_x       = h_cnt_s;
        salida_s.pixel_y       = v_cnt_s;
        salida_s.tick_pixel    = tick_sig_s;
        salida_s.inicio_cuadro = tick_sig_s && (h_cnt_s == '0) && (v_cnt_s == '0);
    end

    // Counter and output registers; everything holds while habilitar is low.
    always_ff @(posedge reloj_nexys or negedge reset_total_n) begin
        if (!reset_total_n) begin
            h_cnt_r  <= '0;
            v_cnt_r  <= '0;
            salida_r <= SALIDA_RESET;
        end else if (bus.habilitar) begin
            h_cnt_r  <= h_cnt_s;
            v_cnt_r  <= v_cnt_s;
            salida_r <= salida_s;
        end else begin
            h_cnt_r  <= h_cnt_r;
            v_cnt_r  <= v_cnt_r;
            salida_r <= salida_r;
        end
    end

    assign bus.hsync         = salida_r.hsync;
    assign bus.vsync         = salida_r.vsync;
    assign bus.video_on      = salida_r.video_on;
    assign bus.pixel_x       = salida_r.pixel_x;
    assign bus.pixel_y       = salida_r.pixel_y;
    assign bus.tick_pixel    = salida_r.tick_pixel;
    assign bus.inicio_cuadro = salida_r.inicio_cuadro;

endmodule

// File: tb/tb_generador_sync_vga.sv
// Bench for generador_sync_vga on a shrunken geometry (25x15 positions, 4 clocks
// per pixel) so whole frames fit in a short run; a per-clock scoreboard plus directed checks.
module tb_generador_sync_vga;
    import vga_timing_pkg::*;

    localparam int D  = 4;
    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int LINEA  = D * HT;
    localparam int CUADRO = LINEA * VT;

    localparam vga_sync_t RST_EXP = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0,
                                      pixel_x: 10'd0, pixel_y: 10'd0,
                                      tick_pixel: 1'b0, inicio_cuadro: 1'b0};

    logic reloj_nexys   = 1'b0;
    logic reset_total_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    generador_sync_vga_if bus ();

    generador_sync_vga #(
        .DIV_PIXEL (D),
        .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_ACTIVO (1'b0)
    ) dut (
        .reloj_nexys   (reloj_nexys),
        .reset_total_n (reset_total_n),
        .bus           (bus)
    );

    always #5 reloj_nexys = ~reloj_nexys;

    vga_sync_t obs_s;
    assign obs_s = {bus.hsync, bus.vsync, bus.video_on, bus.pixel_x, bus.pixel_y,
                    bus.tick_pixel, bus.inicio_cuadro};

    // Expected outputs after e enabled edges since reset: edge 1 shows (0,0), then one clock per step.
    function automatic vga_sync_t modelo(input longint e);
        vga_sync_t m;
        longint    k;
        int        d, px, py;
        m = RST_EXP;
        if (e > 0) begin
            k  = e - 1;
            d  = int'(k % D);
            px = int'((k / D) % HT);
            py = int'((k / (D * HT)) % VT);
            m.hsync         = (px >= HV + HF && px < HV + HF + HS) ? 1'b0 : 1'b1;
            m.vsync         = (py >= VV + VF && py < VV + VF + VS) ? 1'b0 : 1'b1;
            m.video_on      = (px < HV) && (py < VV);
            m.pixel_x       = 10'(px);
            m.pixel_y       = 10'(py);
            m.tick_pixel    = (d == 0);
            m.inicio_cuadro = (d == 0) && (px == 0) && (py == 0);
        end
        return m;
    endfunction

    task automatic chk_sync(input string tag, input vga_sync_t obs, input vga_sync_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    longint    flancos_r = 0;
    vga_sync_t esperado_q[$];

    // Scoreboard producer: one expectation per clock edge from the stimulus seen at that edge.
    always @(posedge reloj_nexys) begin
        if (!reset_total_n) begin
            flancos_r <= 0;
            esperado_q.push_back(modelo(0));
        end else if (bus.habilitar) begin
            flancos_r <= flancos_r + 1;
            esperado_q.push_back(modelo(flancos_r + 1));
        end else begin
            esperado_q.push_back(modelo(flancos_r));
        end
    end

    // Scoreboard consumer: compare on the falling edge; while in reset only reset values are legal.
    always @(negedge reloj_nexys) begin
        if (esperado_q.size() != 0) begin
            if (reset_total_n) begin
                chk_sync("frame", obs_s, esperado_q.pop_front());
            end else begin
                chk_sync("in_reset", obs_s, RST_EXP);
                esperado_q.delete();
            end
        end
    end

    initial begin
        int        n_tick, n_vs_low, n_vs_bad, n_ini, n, n_frz, yp, max_py;
        int        t_px_last, t_vid_off, t_hs_fall, t_hs_rise, t_ini2;
        vga_sync_t snap;
        n_tick = 0; n_vs_low = 0; n_vs_bad = 0; n_ini = 0; max_py = 0;
        t_px_last = -1; t_vid_off = -1; t_hs_fall = -1; t_hs_rise = -1; t_ini2 = -1;

        bus.habilitar = 1'b0;
        reset_total_n = 1'b0;
        repeat (10) @(negedge reloj_nexys);
        chk_sync("reset_hold", obs_s, RST_EXP);

        reset_total_n = 1'b1;
        bus.habilitar = 1'b1;
        for (int i = 0; i <= CUADRO + 100; i++) begin
            @(negedge reloj_nexys);
            if (i == 0) begin
                chk("first_inicio", bus.inicio_cuadro, 1);
                chk("first_tick", bus.tick_pixel, 1);
                chk("first_video", bus.video_on, 1);
            end
            if (i < 40 && bus.tick_pixel) n_tick++;
            if (t_px_last < 0 && bus.pixel_x == 10'(HV - 1)) t_px_last = i;
            if (t_vid_off < 0 && !bus.video_on) t_vid_off = i;
            if (t_hs_fall < 0 && !bus.hsync) t_hs_fall = i;
            if (t_hs_fall >= 0 && t_hs_rise < 0 && bus.hsync) t_hs_rise = i;
            if (i < CUADRO && !bus.vsync) begin
                n_vs_low++;
                if (bus.pixel_y != 10'(VV + VF) && bus.pixel_y != 10'(VV + VF + 1)) n_vs_bad++;
            end
            if (int'(bus.pixel_y) > max_py) max_py = int'(bus.pixel_y);
            if (bus.inicio_cuadro) begin
                n_ini++;
                if (i > 0 && t_ini2 < 0) t_ini2 = i;
            end
        end
        chk("tick_rate", n_tick, 10);
        chk("px_last_visible", t_px_last, (HV - 1) * D);
        chk("video_off", t_vid_off, HV * D);
        chk("hsync_fall", t_hs_fall, (HV + HF) * D);
        chk("hsync_width", t_hs_rise - t_hs_fall, HS * D);
        chk("vsync_width", n_vs_low, VS * LINEA);
        chk("vsync_lines", n_vs_bad, 0);
        chk("py_max", max_py, VT - 1);
        chk("inicio_count", n_ini, 2);
        chk("inicio_period", t_ini2, CUADRO);

        // Freeze at the last pixel of a line, one clock before the wrap.
        n = 0;
        while (!(bus.pixel_x == 10'(HT - 1) && bus.tick_pixel) && n < 2 * LINEA) begin
            @(negedge reloj_nexys);
            n++;
        end
        chk("wait_line_end", (n < 2 * LINEA) ? 1 : 0, 1);
        repeat (D - 1) @(negedge reloj_nexys);
        yp   = int'(bus.pixel_y);
        snap = obs_s;
        bus.habilitar = 1'b0;
        n_frz = 0;
        repeat (37) begin
            @(negedge reloj_nexys);
            if (obs_s !== snap) n_frz++;
        end
        chk("freeze_hold", n_frz, 0);
        bus.habilitar = 1'b1;
        @(negedge reloj_nexys);
        chk("unfreeze_x", bus.pixel_x, 0);
        chk("unfreeze_y", bus.pixel_y, (yp + 1) % VT);
        chk("unfreeze_tick", bus.tick_pixel, 1);

        // Asynchronous reset in the middle of a frame, between clock edges.
        n = 0;
        while (bus.pixel_y != 10'd5 && n < 2 * CUADRO) begin
            @(negedge reloj_nexys);
            n++;
        end
        chk("wait_mid_frame", (n < 2 * CUADRO) ? 1 : 0, 1);
        repeat (3) @(negedge reloj_nexys);
        @(posedge reloj_nexys);
        #2;
        reset_total_n = 1'b0;
        #1;
        chk_sync("async_reset", obs_s, RST_EXP);
        repeat (3) @(negedge reloj_nexys);
        reset_total_n = 1'b1;
        @(negedge reloj_nexys);
        chk("restart_inicio", bus.inicio_cuadro, 1);
        chk("restart_xy", {bus.pixel_x, bus.pixel_y}, 0);
        repeat (2 * LINEA) @(negedge reloj_nexys);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
